// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM sharing one memory port for fetch and data; MC_CTRL_PERF_CNT_EN adds instrCount.
// Latency from FETCH entry: NOP 2, BEQ/BNE/JMP 3, R-type/SW 4, LW 5 cycles.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until memReady; each low cycle adds one.
module multicycle_controller #(
  parameter int OPW   = 6,
  parameter int ALUSW = 3
`ifdef MC_CTRL_PERF_CNT_EN
  , parameter int CNTW = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWriteS,
  output logic [1:0]       pcSrcS,
  output logic             irWriteS,
  output logic             iOrDS,
  output logic             memReadS,
  output logic             memWriteS,
  output logic             aluSrcAS,
  output logic [1:0]       aluSrcBS,
  output logic [ALUSW-1:0] aluS,
  output logic             regDstS,
  output logic             memToRegS,
  output logic             writeRegS,
  output logic             illegalOp
`ifdef MC_CTRL_PERF_CNT_EN
  , output logic [CNTW-1:0] instrCount
`endif
);

  localparam logic [31:0] OP_NOP = 32'd0;
  localparam logic [31:0] OP_ADD = 32'd32;
  localparam logic [31:0] OP_SUB = 32'd34;
  localparam logic [31:0] OP_AND = 32'd3;
  localparam logic [31:0] OP_OR  = 32'd4;
  localparam logic [31:0] OP_SLT = 32'd5;
  localparam logic [31:0] OP_LW  = 32'd6;
  localparam logic [31:0] OP_SW  = 32'd7;
  localparam logic [31:0] OP_JMP = 32'd8;
  localparam logic [31:0] OP_BEQ = 32'd9;
  localparam logic [31:0] OP_BNE = 32'd10;

  localparam logic [ALUSW-1:0] ALU_ADD = ALUSW'(0);
  localparam logic [ALUSW-1:0] ALU_SUB = ALUSW'(1);
  localparam logic [ALUSW-1:0] ALU_AND = ALUSW'(2);
  localparam logic [ALUSW-1:0] ALU_OR  = ALUSW'(3);
  localparam logic [ALUSW-1:0] ALU_LT  = ALUSW'(4);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_RWB      = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LWB      = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  state_t      state, state_next;
  logic [31:0] op_ext;

  // Zero-extend so encodings compare correctly for any OPW up to 32.
  assign op_ext = 32'(opcode);

  function automatic logic [ALUSW-1:0] r_alu(input logic [31:0] op);
    case (op)
      OP_SUB:  r_alu = ALU_SUB;
      OP_AND:  r_alu = ALU_AND;
      OP_OR:   r_alu = ALU_OR;
      OP_SLT:  r_alu = ALU_LT;
      default: r_alu = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    pcWriteS   = 1'b0;
    pcSrcS     = 2'b00;
    irWriteS   = 1'b0;
    iOrDS      = 1'b0;
    memReadS   = 1'b0;
    memWriteS  = 1'b0;
    aluSrcAS   = 1'b0;
    aluSrcBS   = 2'b00;
    aluS       = ALU_ADD;
    regDstS    = 1'b0;
    memToRegS  = 1'b0;
    writeRegS  = 1'b0;
    illegalOp  = 1'b0;
    case (state)
      S_FETCH: begin
        memReadS   = 1'b1;
        aluSrcBS   = 2'b01;
        irWriteS   = memReady;
        pcWriteS   = memReady;
        state_next = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut.
        aluSrcBS = 2'b11;
        case (op_ext)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_next = S_EXEC_R;
          OP_LW, OP_SW:                          state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                        state_next = S_BRANCH;
          OP_JMP:                                state_next = S_JUMP;
          OP_NOP:                                state_next = S_FETCH;
          default: begin
            illegalOp  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        aluSrcAS   = 1'b1;
        aluS       = r_alu(op_ext);
        state_next = S_RWB;
      end
      S_RWB: begin
        writeRegS = 1'b1;
        regDstS   = 1'b1;
      end
      S_MEM_ADDR: begin
        aluSrcAS = 1'b1;
        aluSrcBS = 2'b10;
        // An opcode that stopped being a memory op aborts rather than touching memory.
        if (op_ext == OP_LW)      state_next = S_MEM_RD;
        else if (op_ext == OP_SW) state_next = S_MEM_WR;
        else                      state_next = S_FETCH;
      end
      S_MEM_RD: begin
        memReadS   = 1'b1;
        iOrDS      = 1'b1;
        state_next = memReady ? S_LWB : S_MEM_RD;
      end
      S_LWB: begin
        writeRegS = 1'b1;
        memToRegS = 1'b1;
      end
      S_MEM_WR: begin
        memWriteS  = 1'b1;
        iOrDS      = 1'b1;
        state_next = memReady ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        aluSrcAS = 1'b1;
        aluS     = ALU_SUB;
        pcSrcS   = 2'b01;
        pcWriteS = ((op_ext == OP_BEQ) && zero) || ((op_ext == OP_BNE) && !zero);
      end
      S_JUMP: begin
        pcSrcS   = 2'b10;
        pcWriteS = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

`ifdef MC_CTRL_PERF_CNT_EN
  logic retire;

  // Retirement is any completed instruction re-entering FETCH; RST and stalls are excluded.
  assign retire = (state_next == S_FETCH) &&
                  ((state == S_RWB) || (state == S_LWB) || (state == S_MEM_WR) ||
                   (state == S_BRANCH) || (state == S_JUMP) || (state == S_DECODE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instrCount <= '0;
    else if (retire) instrCount <= instrCount + CNTW'(1);
  end
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: directed scenarios plus an instruction-level trace model.
module tb_multicycle_controller;
  localparam int OPW   = 6;
  localparam int ALUSW = 3;
`ifdef MC_CTRL_PERF_CNT_EN
  localparam int CNTW = 4;
  logic [CNTW-1:0] instrCount;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [OPW-1:0] opcode = '0;
  logic zero = 1'b0;
  logic memReady = 1'b0;
  logic pcWriteS, irWriteS, iOrDS, memReadS, memWriteS, aluSrcAS;
  logic regDstS, memToRegS, writeRegS, illegalOp;
  logic [1:0] pcSrcS, aluSrcBS;
  logic [ALUSW-1:0] aluS;

  typedef struct packed {
    logic pcw; logic [1:0] pcsrc; logic irw; logic iord; logic memr; logic memw;
    logic asa; logic [1:0] asb; logic [2:0] alu; logic rdst; logic m2r; logic wreg; logic ill;
  } ovec_t;

  typedef struct packed {
    logic [5:0] op; logic z; logic rdy; ovec_t exp;
  } step_t;

  ovec_t obs;
  step_t trace[$];
  int vectors = 0;
  int miscompares = 0;

  assign obs = {pcWriteS, pcSrcS, irWriteS, iOrDS, memReadS, memWriteS, aluSrcAS,
                aluSrcBS, aluS, regDstS, memToRegS, writeRegS, illegalOp};

  always #5 clk = ~clk;

  multicycle_controller #(
    .OPW(OPW), .ALUSW(ALUSW)
`ifdef MC_CTRL_PERF_CNT_EN
    , .CNTW(CNTW)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcWriteS(pcWriteS), .pcSrcS(pcSrcS), .irWriteS(irWriteS), .iOrDS(iOrDS),
    .memReadS(memReadS), .memWriteS(memWriteS), .aluSrcAS(aluSrcAS), .aluSrcBS(aluSrcBS),
    .aluS(aluS), .regDstS(regDstS), .memToRegS(memToRegS), .writeRegS(writeRegS),
    .illegalOp(illegalOp)
`ifdef MC_CTRL_PERF_CNT_EN
    , .instrCount(instrCount)
`endif
  );

  function automatic logic [5:0] rnd6();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input int op);
    return op inside {0, 32, 34, 3, 4, 5, 6, 7, 8, 9, 10};
  endfunction

  function automatic int pick_op();
    int legal[11] = '{0, 32, 34, 3, 4, 5, 6, 7, 8, 9, 10};
    int op;
    if ($urandom_range(0, 7) == 0) begin
      do op = int'($urandom_range(0, 63)); while (is_legal(op));
    end else begin
      op = legal[$urandom_range(0, 10)];
    end
    return op;
  endfunction

  function automatic void push(input logic [5:0] op, input logic z, input logic rdy, input ovec_t e);
    trace.push_back({op, z, rdy, e});
  endfunction

  // Expected cycle-by-cycle outputs of one instruction with fw fetch and mw data wait cycles.
  // Inputs the controller must ignore are randomized in every step where they do not matter.
  function automatic void build(input int op, input logic z, input int fw, input int mw);
    ovec_t e, f;
    logic [5:0] o;
    o = op[5:0];
    f = '0; f.memr = 1'b1; f.asb = 2'b01;
    for (int i = 0; i < fw; i++) push(rnd6(), rb(), 1'b0, f);
    e = f; e.irw = 1'b1; e.pcw = 1'b1;
    push(rnd6(), rb(), 1'b1, e);
    e = '0; e.asb = 2'b11; e.ill = !is_legal(op);
    push(o, rb(), rb(), e);
    case (op)
      32, 34, 3, 4, 5: begin
        e = '0; e.asa = 1'b1;
        e.alu = (op == 32) ? 3'd0 : (op == 34) ? 3'd1 : (op == 3) ? 3'd2 : (op == 4) ? 3'd3 : 3'd4;
        push(o, rb(), rb(), e);
        e = '0; e.wreg = 1'b1; e.rdst = 1'b1;
        push(rnd6(), rb(), rb(), e);
      end
      6, 7: begin
        e = '0; e.asa = 1'b1; e.asb = 2'b10;
        push(o, rb(), rb(), e);
        e = '0; e.iord = 1'b1;
        if (op == 6) e.memr = 1'b1; else e.memw = 1'b1;
        for (int i = 0; i < mw; i++) push(rnd6(), rb(), 1'b0, e);
        push(rnd6(), rb(), 1'b1, e);
        if (op == 6) begin
          e = '0; e.wreg = 1'b1; e.m2r = 1'b1;
          push(rnd6(), rb(), rb(), e);
        end
      end
      9, 10: begin
        e = '0; e.asa = 1'b1; e.alu = 3'd1; e.pcsrc = 2'b01;
        e.pcw = (op == 9) ? z : !z;
        push(o, z, rb(), e);
      end
      8: begin
        e = '0; e.pcsrc = 2'b10; e.pcw = 1'b1;
        push(rnd6(), rb(), rb(), e);
      end
      default: ;
    endcase
  endfunction

  task automatic cyc(input logic [5:0] op, input logic z, input logic rdy);
    @(negedge clk);
    opcode = op; zero = z; memReady = rdy;
    #1;
  endtask

  task automatic run_trace(input string name);
    step_t s;
    while (trace.size() > 0) begin
      s = trace.pop_front();
      cyc(s.op, s.z, s.rdy);
      vectors++;
      if (obs !== s.exp) begin
        miscompares++;
        $display("FAIL %s outputs: got %h expected %h (op=%0d rdy=%0b)", name, obs, s.exp, s.op, s.rdy);
      end
      vectors++;
      if ({memReadS & memWriteS, irWriteS & writeRegS} !== 2'b00) begin
        miscompares++;
        $display("FAIL %s exclusivity: rd&wr,ir&wreg got %b%b expected 00", name,
                 memReadS & memWriteS, irWriteS & writeRegS);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memReady = 1'b1; opcode = 6'd32;
    repeat (2) begin
      @(negedge clk); #1;
      vectors++;
      if (obs !== '0) begin miscompares++; $display("FAIL reset_hold: got %h expected 0", obs); end
    end
`ifdef MC_CTRL_PERF_CNT_EN
    vectors++;
    if (instrCount !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", instrCount); end
`endif
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL rst_state: got %h expected 0", obs); end
  endtask

  task automatic test_rtype();
    cyc(rnd6(), 1'b0, 1'b1);
    vectors++;
    if ({irWriteS, pcWriteS, memReadS, writeRegS} !== 4'b1110) begin
      miscompares++; $display("FAIL rtype_fetch: got %b expected 1110", {irWriteS, pcWriteS, memReadS, writeRegS});
    end
    cyc(6'd32, 1'b0, 1'b1);
    vectors++;
    if ({aluSrcBS, writeRegS} !== 3'b110) begin
      miscompares++; $display("FAIL rtype_decode: got %b expected 110", {aluSrcBS, writeRegS});
    end
    cyc(6'd32, 1'b0, 1'b1);
    vectors++;
    if ({aluS, aluSrcAS, writeRegS, regDstS} !== 6'b000100) begin
      miscompares++; $display("FAIL rtype_exec: got %b expected 000100", {aluS, aluSrcAS, writeRegS, regDstS});
    end
    cyc(rnd6(), 1'b0, 1'b1);
    vectors++;
    if ({writeRegS, regDstS, memToRegS} !== 3'b110) begin
      miscompares++; $display("FAIL rtype_rwb: got %b expected 110", {writeRegS, regDstS, memToRegS});
    end
    cyc(6'd0, 1'b0, 1'b0);
    vectors++;
    if ({memReadS, writeRegS, regDstS} !== 3'b100) begin
      miscompares++; $display("FAIL rtype_refetch: got %b expected 100", {memReadS, writeRegS, regDstS});
    end
  endtask

  task automatic test_lw_wait();
    int n = 0;
    cyc(rnd6(), 1'b0, 1'b1);
    cyc(6'd6, 1'b0, 1'b1);
    cyc(6'd6, 1'b0, 1'b0);
    vectors++;
    if ({aluSrcAS, aluSrcBS, aluS} !== 6'b110000) begin
      miscompares++; $display("FAIL lw_addr: got %b expected 110000", {aluSrcAS, aluSrcBS, aluS});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(rnd6(), 1'b0, (i == 2));
      if (memReadS && iOrDS && !memWriteS) n++;
    end
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL lw_wait_cycles: got %0d expected 3", n); end
    cyc(rnd6(), 1'b0, 1'b1);
    vectors++;
    if ({writeRegS, memToRegS, regDstS} !== 3'b110) begin
      miscompares++; $display("FAIL lw_wb: got %b expected 110", {writeRegS, memToRegS, regDstS});
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[3] = '{6'd9, 6'd10, 6'd10};
    logic zs[3] = '{1'b1, 1'b1, 1'b0};
    logic pw[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      cyc(rnd6(), 1'b0, 1'b1);
      cyc(ops[i], zs[i], 1'b0);
      cyc(ops[i], zs[i], 1'b0);
      vectors++;
      if ({pcWriteS, pcSrcS} !== {pw[i], 2'b01}) begin
        miscompares++;
        $display("FAIL branch_%0d: got %b expected %b", i, {pcWriteS, pcSrcS}, {pw[i], 2'b01});
      end
    end
  endtask

  task automatic test_illegal();
    int pulses = 0;
    int bad = 0;
    cyc(rnd6(), 1'b0, 1'b1);
    cyc(6'd63, 1'b0, 1'b0);
    if (illegalOp) pulses++;
    vectors++;
    if (illegalOp !== 1'b1) begin miscompares++; $display("FAIL illegal_decode: got %b expected 1", illegalOp); end
    for (int i = 0; i < 3; i++) begin
      cyc(6'd63, 1'b0, 1'b0);
      if (illegalOp) pulses++;
      if ({writeRegS, memWriteS, pcWriteS, memReadS} !== 4'b0001) bad++;
    end
    vectors++;
    if (pulses !== 1) begin miscompares++; $display("FAIL illegal_pulse: got %0d expected 1", pulses); end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL illegal_refetch: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid_write();
    cyc(rnd6(), 1'b0, 1'b1);
    cyc(6'd7, 1'b0, 1'b0);
    cyc(6'd7, 1'b0, 1'b0);
    cyc(rnd6(), 1'b0, 1'b0);
    cyc(rnd6(), 1'b0, 1'b0);
    vectors++;
    if ({memWriteS, iOrDS, memReadS} !== 3'b110) begin
      miscompares++; $display("FAIL sw_stall: got %b expected 110", {memWriteS, iOrDS, memReadS});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL async_reset: got %h expected 0", obs); end
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL post_reset_rst: got %h expected 0", obs); end
    cyc(rnd6(), 1'b0, 1'b0);
    vectors++;
    if ({memReadS, iOrDS, memWriteS, irWriteS} !== 4'b1000) begin
      miscompares++; $display("FAIL post_reset_fetch: got %b expected 1000", {memReadS, iOrDS, memWriteS, irWriteS});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      build(pick_op(), rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      run_trace("random");
    end
  endtask

`ifdef MC_CTRL_PERF_CNT_EN
  task automatic test_perf();
    int retired;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    build(32, rb(), 0, 0);
    build(0, rb(), 1, 0);
    build(6, rb(), 0, 1);
    run_trace("perf");
    @(posedge clk); #1;
    vectors++;
    if (instrCount !== CNTW'(3)) begin miscompares++; $display("FAIL perf_three: got %0d expected 3", instrCount); end
    retired = 3;
    for (int k = 0; k < 13; k++) begin
      build(pick_op(), rb(), 0, int'($urandom_range(0, 1)));
      retired++;
    end
    run_trace("perf_wrap");
    @(posedge clk); #1;
    vectors++;
    if (instrCount !== CNTW'(retired % 16)) begin
      miscompares++; $display("FAIL perf_wrap: got %0d expected %0d", instrCount, retired % 16);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_reset_mid_write();
    test_random();
`ifdef MC_CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
